// File: rtl/led_pkg.sv
// +----------------------------------------------------------------------+
// | led_pkg : shared types and helpers for the multi-channel LED ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    BL_IDLE  = 2'd0,
    BL_ON    = 2'd1,
    BL_OFF   = 2'd2,
    BL_PAUSE = 2'd3
  } blink_state_e;

  typedef enum logic [1:0] {
    BT_ALL_ON  = 2'd0,
    BT_ALL_OFF = 2'd1,
    BT_RUN     = 2'd2
  } boot_state_e;

  localparam int unsigned CODE_W = 3;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Counters are sized so their terminal value always fits, never wraps.
  function automatic int unsigned cnt_width(input int unsigned term);
    return $clog2(term) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_blink_ch.sv
// +----------------------------------------------------------------------+
// | led_blink_ch : one channel's red blink-code FSM and green stretcher  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module led_blink_ch
  import led_pkg::*;
#(
  parameter int unsigned FLASH_MS   = 200,
  parameter int unsigned PAUSE_MS   = 1000,
  parameter int unsigned STRETCH_MS = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_ms_i,
  input  logic              run_i,
  input  logic              act_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              red_on_o,
  output logic              gr_on_o
);

  localparam int unsigned TMR_TERM = ((FLASH_MS > PAUSE_MS) ? FLASH_MS : PAUSE_MS) - 1;
  localparam int unsigned TMR_W    = cnt_width(TMR_TERM);
  localparam int unsigned STR_W    = cnt_width(STRETCH_MS);

  localparam logic [TMR_W-1:0] FLASH_LAST = TMR_W'(FLASH_MS - 1);
  localparam logic [TMR_W-1:0] PAUSE_LAST = TMR_W'(PAUSE_MS - 1);
  localparam logic [STR_W-1:0] STR_LOAD   = STR_W'(STRETCH_MS);

  blink_state_e      state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] n_q, n_d;
  logic [STR_W-1:0]  str_q, str_d;
  logic              tmr_last;

  always_comb begin
    tmr_last = 1'b0;
    case (state_q)
      BL_ON, BL_OFF: tmr_last = (tmr_q == FLASH_LAST);
      BL_PAUSE:      tmr_last = (tmr_q == PAUSE_LAST);
      default:       tmr_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    code_d  = code_q;
    n_d     = n_q;
    case (state_q)
      BL_IDLE: begin
        if (run_i && (code_i != '0)) begin
          code_d  = code_i;
          n_d     = CODE_W'(1);
          tmr_d   = '0;
          state_d = BL_ON;
        end
      end
      default: begin
        // A cleared code aborts immediately; other code changes wait for IDLE.
        if (code_i == '0) begin
          tmr_d   = '0;
          state_d = BL_IDLE;
        end else if (tick_ms_i) begin
          if (tmr_last) begin
            tmr_d = '0;
            case (state_q)
              BL_ON: state_d = BL_OFF;
              BL_OFF: begin
                if (n_q == code_q) begin
                  state_d = BL_PAUSE;
                end else begin
                  n_d     = n_q + CODE_W'(1);
                  state_d = BL_ON;
                end
              end
              default: state_d = BL_IDLE;
            endcase
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    str_d = str_q;
    if (act_i) begin
      str_d = STR_LOAD;
    end else if (tick_ms_i && (str_q != '0)) begin
      str_d = str_q - STR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BL_IDLE;
      tmr_q   <= '0;
      code_q  <= '0;
      n_q     <= '0;
      str_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      code_q  <= code_d;
      n_q     <= n_d;
      str_q   <= str_d;
    end
  end

  assign red_on_o = (state_q == BL_IDLE) || (state_q == BL_ON);
  assign gr_on_o  = act_i || (str_q != '0);

endmodule

`default_nettype wire

// File: rtl/led_ctrl_mc.sv
// +----------------------------------------------------------------------+
// | led_ctrl_mc : multi-channel front-panel LED controller (boot+codes)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module led_ctrl_mc
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 60000000,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned BOOT_MS    = 1000,
  parameter int unsigned FLASH_MS   = 200,
  parameter int unsigned PAUSE_MS   = 1000,
  parameter int unsigned STRETCH_MS = 20,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_res_n,
  input  logic [N_CH-1:0]          i_act,
  input  logic [CODE_W*N_CH-1:0]   i_err_code,
  input  logic                     i_lamp_test,
  output logic [N_CH-1:0]          o_led_red,
  output logic [N_CH-1:0]          o_led_gr,
  output logic                     o_boot_done
);

  localparam int unsigned PRE_TERM  = ms_to_cycles(CLK_HZ, 1) - 1;
  localparam int unsigned PRE_W     = cnt_width(PRE_TERM);
  localparam int unsigned BOOT_TERM = BOOT_MS - 1;
  localparam int unsigned BOOT_W    = cnt_width(BOOT_TERM);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_TERM);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_TERM);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [BOOT_W-1:0] bms_q, bms_d;
  boot_state_e       boot_q, boot_d;
  logic              tick_ms;
  logic              run;
  logic [N_CH-1:0]   ch_red, ch_gr;
  logic [N_CH-1:0]   red_on, gr_on;

  assign tick_ms = (pre_q == PRE_LAST);
  assign pre_d   = tick_ms ? '0 : pre_q + PRE_W'(1);

  always_comb begin
    boot_d = boot_q;
    bms_d  = bms_q;
    if ((boot_q != BT_RUN) && tick_ms) begin
      if (bms_q == BOOT_LAST) begin
        bms_d  = '0;
        boot_d = (boot_q == BT_ALL_ON) ? BT_ALL_OFF : BT_RUN;
      end else begin
        bms_d = bms_q + BOOT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      pre_q  <= '0;
      bms_q  <= '0;
      boot_q <= BT_ALL_ON;
    end else begin
      pre_q  <= pre_d;
      bms_q  <= bms_d;
      boot_q <= boot_d;
    end
  end

  assign run         = (boot_q == BT_RUN);
  assign o_boot_done = run;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    led_blink_ch #(
      .FLASH_MS   (FLASH_MS),
      .PAUSE_MS   (PAUSE_MS),
      .STRETCH_MS (STRETCH_MS)
    ) u_ch (
      .clk_i     (i_clk),
      .rst_ni    (i_res_n),
      .tick_ms_i (tick_ms),
      .run_i     (run),
      .act_i     (i_act[c]),
      .code_i    (i_err_code[CODE_W*c +: CODE_W]),
      .red_on_o  (ch_red[c]),
      .gr_on_o   (ch_gr[c])
    );
  end

  // Lamp test only overrides the pins; channel FSMs keep running underneath.
  always_comb begin
    red_on = ch_red;
    gr_on  = ch_gr;
    case (boot_q)
      BT_ALL_ON: begin
        red_on = '1;
        gr_on  = '1;
      end
      BT_ALL_OFF: begin
        red_on = '0;
        gr_on  = '0;
      end
      default: begin
        if (i_lamp_test) begin
          red_on = '1;
          gr_on  = '1;
        end
      end
    endcase
  end

  assign o_led_red = red_on ^ {N_CH{ACTIVE_LOW}};
  assign o_led_gr  = gr_on ^ {N_CH{ACTIVE_LOW}};

endmodule

`default_nettype wire

// File: tb/tb_led_ctrl_mc.sv
// +----------------------------------------------------------------------+
// | tb_led_ctrl_mc : scoreboard bench, active-high and active-low DUTs   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_led_ctrl_mc;

  logic       clk = 1'b0;
  logic       res_n;
  logic [1:0] act;
  logic [5:0] code;
  logic       lamp;
  logic [1:0] red, gr, red_al, gr_al;
  logic       boot, boot_al;

  always #5 clk = ~clk;

  led_ctrl_mc #(
    .CLK_HZ(4000), .N_CH(2), .BOOT_MS(3), .FLASH_MS(2), .PAUSE_MS(5),
    .STRETCH_MS(3), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .i_clk(clk), .i_res_n(res_n), .i_act(act), .i_err_code(code),
    .i_lamp_test(lamp), .o_led_red(red), .o_led_gr(gr), .o_boot_done(boot)
  );

  led_ctrl_mc #(
    .CLK_HZ(4000), .N_CH(2), .BOOT_MS(3), .FLASH_MS(2), .PAUSE_MS(5),
    .STRETCH_MS(3), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .i_clk(clk), .i_res_n(res_n), .i_act(act), .i_err_code(code),
    .i_lamp_test(lamp), .o_led_red(red_al), .o_led_gr(gr_al), .o_boot_done(boot_al)
  );

  typedef struct {
    int         stamp;
    string      name;
    logic [1:0] red;
    logic [1:0] gr;
    logic       boot;
  } exp_t;

  exp_t sb[$];
  int   gcyc   = 0;
  int   base   = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic expect_at(input int k, input string nm, input logic [1:0] r,
                           input logic [1:0] g, input logic b);
    exp_t e;
    e.stamp = base + k;
    e.name  = nm;
    e.red   = r;
    e.gr    = g;
    e.boot  = b;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int k);
    while (gcyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    base  = gcyc;
    res_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation on the negedge of its cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].stamp <= gcyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.stamp < gcyc) begin
          n_fail++;
          $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.stamp, gcyc);
        end else if (red !== e.red || gr !== e.gr || boot !== e.boot ||
                     red_al !== ~e.red || gr_al !== ~e.gr || boot_al !== e.boot) begin
          n_fail++;
          $display("FAIL %s: got red=%b gr=%b boot=%b red_al=%b gr_al=%b boot_al=%b, want red=%b gr=%b boot=%b red_al=%b gr_al=%b",
                   e.name, red, gr, boot, red_al, gr_al, boot_al,
                   e.red, e.gr, e.boot, ~e.red, ~e.gr);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    res_n = 1'b0;
    act   = 2'b00;
    code  = 6'd0;
    lamp  = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();

    // Boot sequence
    expect_at(0,   "boot_on_start",  2'b11, 2'b11, 1'b0);
    expect_at(11,  "boot_on_end",    2'b11, 2'b11, 1'b0);
    expect_at(12,  "boot_off_start", 2'b00, 2'b00, 1'b0);
    expect_at(23,  "boot_off_end",   2'b00, 2'b00, 1'b0);
    expect_at(24,  "run_first",      2'b11, 2'b00, 1'b1);
    // ch0 code 3
    expect_at(25,  "c3_on1_start",   2'b11, 2'b00, 1'b1);
    expect_at(31,  "c3_on1_end",     2'b11, 2'b00, 1'b1);
    expect_at(32,  "c3_off1",        2'b10, 2'b00, 1'b1);
    expect_at(39,  "c3_off1_end",    2'b10, 2'b00, 1'b1);
    expect_at(40,  "c3_on2",         2'b11, 2'b00, 1'b1);
    expect_at(48,  "c3_off2",        2'b10, 2'b00, 1'b1);
    expect_at(56,  "c3_on3",         2'b11, 2'b00, 1'b1);
    expect_at(64,  "c3_off3",        2'b10, 2'b00, 1'b1);
    expect_at(71,  "c3_off3_end",    2'b10, 2'b00, 1'b1);
    expect_at(72,  "c3_pause",       2'b10, 2'b00, 1'b1);
    expect_at(91,  "c3_pause_end",   2'b10, 2'b00, 1'b1);
    expect_at(92,  "c3_idle",        2'b11, 2'b00, 1'b1);
    expect_at(93,  "c3_rep_on",      2'b11, 2'b00, 1'b1);
    expect_at(100, "c3_rep_off",     2'b10, 2'b00, 1'b1);
    expect_at(101, "c3_cleared",     2'b11, 2'b00, 1'b1);
    // ch1 code 2, cleared in second OFF
    expect_at(105, "c2_on1",         2'b11, 2'b00, 1'b1);
    expect_at(112, "c2_off1",        2'b01, 2'b00, 1'b1);
    expect_at(119, "c2_off1_end",    2'b01, 2'b00, 1'b1);
    expect_at(120, "c2_on2",         2'b11, 2'b00, 1'b1);
    expect_at(128, "c2_off2",        2'b01, 2'b00, 1'b1);
    expect_at(130, "c2_off2_clr",    2'b01, 2'b00, 1'b1);
    expect_at(131, "c2_cleared",     2'b11, 2'b00, 1'b1);
    expect_at(140, "c2_no_pause",    2'b11, 2'b00, 1'b1);
    expect_at(160, "c2_quiet",       2'b11, 2'b00, 1'b1);
    // Activity stretch
    expect_at(169, "act_idle",       2'b11, 2'b00, 1'b1);
    expect_at(170, "act_same_cyc",   2'b11, 2'b10, 1'b1);
    expect_at(179, "act_stretch",    2'b11, 2'b10, 1'b1);
    expect_at(180, "act_expired",    2'b11, 2'b00, 1'b1);
    expect_at(190, "act2_first",     2'b11, 2'b10, 1'b1);
    expect_at(197, "act2_second",    2'b11, 2'b10, 1'b1);
    expect_at(200, "act2_extended",  2'b11, 2'b10, 1'b1);
    expect_at(207, "act2_ext_end",   2'b11, 2'b10, 1'b1);
    expect_at(208, "act2_expired",   2'b11, 2'b00, 1'b1);
    // ch0 code 5 with lamp test over part of it
    expect_at(213, "c5_on1",         2'b11, 2'b00, 1'b1);
    expect_at(220, "c5_off1",        2'b10, 2'b00, 1'b1);
    expect_at(228, "c5_on2",         2'b11, 2'b00, 1'b1);
    expect_at(230, "lamp_on",        2'b11, 2'b11, 1'b1);
    expect_at(236, "lamp_over_off",  2'b11, 2'b11, 1'b1);
    expect_at(249, "lamp_last",      2'b11, 2'b11, 1'b1);
    expect_at(250, "lamp_released",  2'b11, 2'b00, 1'b1);
    expect_at(252, "c5_off3",        2'b10, 2'b00, 1'b1);
    expect_at(260, "c5_on4",         2'b11, 2'b00, 1'b1);
    expect_at(268, "c5_off4",        2'b10, 2'b00, 1'b1);
    expect_at(276, "c5_on5",         2'b11, 2'b00, 1'b1);
    expect_at(284, "c5_off5",        2'b10, 2'b00, 1'b1);
    expect_at(292, "c5_pause",       2'b10, 2'b00, 1'b1);
    expect_at(311, "c5_pause_end",   2'b10, 2'b00, 1'b1);
    expect_at(312, "c5_idle",        2'b11, 2'b00, 1'b1);
    expect_at(318, "c5_stopped",     2'b11, 2'b00, 1'b1);
    // Asynchronous reset mid-RUN, seen before the next clock edge
    expect_at(320, "async_reset",    2'b11, 2'b11, 1'b0);

    wait_to(24);  code[2:0] = 3'd3;
    wait_to(100); code[2:0] = 3'd0;
    wait_to(104); code[5:3] = 3'd2;
    wait_to(130); code[5:3] = 3'd0;
    wait_to(170); act = 2'b10;
    wait_to(171); act = 2'b00;
    wait_to(190); act = 2'b10;
    wait_to(191); act = 2'b00;
    wait_to(197); act = 2'b10;
    wait_to(198); act = 2'b00;
    wait_to(212); code[2:0] = 3'd5;
    wait_to(230); lamp = 1'b1;
    wait_to(250); lamp = 1'b0;
    wait_to(312); code[2:0] = 3'd0;
    wait_to(320);
    #1;
    res_n = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();

    expect_at(0,  "reboot_on",       2'b11, 2'b11, 1'b0);
    expect_at(11, "reboot_on_end",   2'b11, 2'b11, 1'b0);
    expect_at(12, "reboot_off",      2'b00, 2'b00, 1'b0);
    expect_at(23, "reboot_off_end",  2'b00, 2'b00, 1'b0);
    expect_at(24, "reboot_run",      2'b11, 2'b00, 1'b1);
    expect_at(30, "reboot_steady",   2'b11, 2'b00, 1'b1);
    wait_to(30);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_ctrl_mc.md
Name: led_ctrl_mc

Overview:
- Parametrised multi-channel successor of the transceiver front-panel LED controller.
- Per channel, drives a red status LED and a green activity LED.
- Power-up lamp sequence: all on, then all off.
- After boot, red shows a repeating N-blink error code and green shows pulse-stretched link activity.
- Sits at top level between the per-channel TX/RX link logic and the LED pins.

Parameters:
- CLK_HZ, 60000000: i_clk frequency; must be a multiple of 1000.
- N_CH, 2: number of channels (e.g. TX, RX); must be at least 1.
- BOOT_MS, 1000: duration of each boot phase (ALL_ON, ALL_OFF).
- FLASH_MS, 200: on time and off time of one error blink.
- PAUSE_MS, 1000: dark gap between blink-code repetitions.
- STRETCH_MS, 20: minimum green on-time after activity; 0 = pure pass-through.
- ACTIVE_LOW, 0: 1 inverts all LED outputs at the pins.

Ports:
- i_clk, in, 1: system clock.
- i_res_n, in, 1: reset.
- i_act, in, N_CH: per-channel activity/data level; synchronous to i_clk.
- i_err_code, in, 3*N_CH: per-channel error code, channel c at bits [3c+2:3c]; 0 = no error, 1..7 = blink count.
- i_lamp_test, in, 1: forces all LEDs on after boot.
- o_led_red, out, N_CH: red LED drive.
- o_led_gr, out, N_CH: green LED drive.
- o_boot_done, out, 1: high once the boot sequence has finished.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_res_n is asynchronous, active-low. Release is synchronous to the i_clk edge.
- Output polarity: every LED is first computed as a logical "on". The pin value is on XOR ACTIVE_LOW.
- Prescaler: counts 0..CLK_HZ/1000-1 and wraps. tick_ms is high for the one cycle at the terminal count. All ms timers advance only on tick_ms.
- Boot FSM states: ALL_ON -> ALL_OFF -> RUN. RUN is sticky until reset.
  - A ms counter advances each phase when tick_ms occurs at count BOOT_MS-1.
  - ALL_ON therefore lasts exactly BOOT_MS*CLK_HZ/1000 cycles from reset release. ALL_OFF lasts the same.
- Reset values: boot state ALL_ON, so o_led_red and o_led_gr are all logical on. o_boot_done = 0. All timers, stretch counters and blink FSMs are cleared.
- o_boot_done goes to 1 on the first cycle of RUN.
- Output mux, in priority order:
  - ALL_ON: logical on.
  - ALL_OFF: logical off.
  - RUN with i_lamp_test = 1: logical on.
  - Otherwise: per-channel blink and stretch outputs.
  - Lamp test does not disturb the FSMs or counters.
- Blink FSM, one per channel, states IDLE, ON, OFF, PAUSE. It is held in IDLE until RUN.
  - IDLE: red on (healthy). When code != 0, latch code, set blink count n=1, clear timer, go to ON on the next cycle.
  - ON: red on. After FLASH_MS ticks go to OFF.
  - OFF: red off. After FLASH_MS ticks: if n == latched code go to PAUSE, else n++ and go to ON.
  - PAUSE: red off. After PAUSE_MS ticks go to IDLE. IDLE re-samples the code, so a persistent error repeats.
  - Timer is tick-aligned, so the first ON period may be up to 1 ms short. Later periods are exact.
  - Code changes to a different nonzero value mid-sequence are ignored until the next IDLE.
  - Code changes to 0 in ON, OFF or PAUSE: the FSM goes to IDLE on the next cycle.
- Activity stretch, per channel:
  - While i_act = 1, the counter loads STRETCH_MS.
  - Otherwise the counter decrements on tick_ms, saturating at 0.
  - Green is on = i_act OR counter != 0. Green turn-on latency in RUN is 0 cycles (combinational from i_act).
  - With STRETCH_MS = 0, green = i_act.
- Width rules: every counter width is $clog2 of its terminal value plus 1. No counter may wrap past its terminal value.
- Reset asserted mid-operation: all state returns to reset values and the boot sequence restarts.

Decomposition:
- Shared package led_pkg: blink-state enum (IDLE/ON/OFF/PAUSE), boot-state enum, function ms_to_cycles.
- One sub-module, led_blink_ch, instantiated N_CH times in a generate loop. It holds one blink FSM plus one stretch counter and consumes the shared tick_ms.
- Prescaler and boot FSM live in the top module.

Test Plan (CLK_HZ=4000 so 1 ms = 4 cycles; BOOT_MS=3, FLASH_MS=2, PAUSE_MS=5, STRETCH_MS=3, N_CH=2):
1. Boot sequence: release reset -> red/green = 2'b11 for 12 cycles, then 2'b00 for 12 cycles; o_boot_done rises at cycle 24; red = 2'b11 and green = 2'b00 with no activity.
2. Blink code: after boot, ch0 code=3 held -> red[0] shows 3 on/off pairs of 8 cycles each (first ON may be shorter), then 20 cycles off, then repeats; red[1] stays on.
3. Error clear: ch1 code=2, set to 0 during the second OFF -> red[1] on from the next cycle; no further blinks.
4. Activity stretch: 1-cycle i_act[1] pulse -> green[1] on the same cycle, off 9..12 cycles later; a second pulse within that window extends the on-time.
5. Lamp test: i_lamp_test=1 during a code-5 sequence -> all outputs on; deassert -> blink continues in phase, since FSM state was never disturbed.
6. ACTIVE_LOW=1 and mid-RUN reset: reset asserted -> pins read 0 (logical on) asynchronously and o_boot_done=0; boot restarts on release.
